// File: rtl/axil_fw_wdg.sv
// AXI-Lite inline firewall: address-window DECERR, per-path watchdog with sticky
// hang isolation, and saturating per-class error counters. Write and read paths are independent.
module axil_fw_wdg #(
  parameter int                  G_ADDR_W  = 20,
  parameter int                  G_DATA_W  = 32,
  parameter int                  G_WD_WDT  = 8,
  parameter int                  G_CNT_WDT = 4,
  parameter logic [G_ADDR_W-1:0] G_BASE    = 20'h00000,
  parameter logic [G_ADDR_W:0]   G_SIZE    = 21'h10000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [G_WD_WDT-1:0]      i_len,
  input  logic                     i_clr,
  input  logic                     s_axil_awvalid,
  input  logic [G_ADDR_W-1:0]      s_axil_awaddr,
  input  logic [2:0]               s_axil_awprot,
  output logic                     s_axil_awready,
  input  logic                     s_axil_wvalid,
  input  logic [G_DATA_W-1:0]      s_axil_wdata,
  input  logic [G_DATA_W/8-1:0]    s_axil_wstrb,
  output logic                     s_axil_wready,
  output logic                     s_axil_bvalid,
  output logic [1:0]               s_axil_bresp,
  input  logic                     s_axil_bready,
  input  logic                     s_axil_arvalid,
  input  logic [G_ADDR_W-1:0]      s_axil_araddr,
  input  logic [2:0]               s_axil_arprot,
  output logic                     s_axil_arready,
  output logic                     s_axil_rvalid,
  output logic [G_DATA_W-1:0]      s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  input  logic                     s_axil_rready,
  output logic                     m_axil_awvalid,
  output logic [G_ADDR_W-1:0]      m_axil_awaddr,
  output logic [2:0]               m_axil_awprot,
  input  logic                     m_axil_awready,
  output logic                     m_axil_wvalid,
  output logic [G_DATA_W-1:0]      m_axil_wdata,
  output logic [G_DATA_W/8-1:0]    m_axil_wstrb,
  input  logic                     m_axil_wready,
  input  logic                     m_axil_bvalid,
  input  logic [1:0]               m_axil_bresp,
  output logic                     m_axil_bready,
  output logic                     m_axil_arvalid,
  output logic [G_ADDR_W-1:0]      m_axil_araddr,
  output logic [2:0]               m_axil_arprot,
  input  logic                     m_axil_arready,
  input  logic                     m_axil_rvalid,
  input  logic [G_DATA_W-1:0]      m_axil_rdata,
  input  logic [1:0]               m_axil_rresp,
  output logic                     m_axil_rready,
  output logic                     o_wr_hung,
  output logic                     o_rd_hung,
  output logic [6*G_CNT_WDT-1:0]   o_err_cnt,
  output logic                     o_irq
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_FWD = 2'd1, W_RESP = 2'd2, W_SRESP = 2'd3} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FWD = 2'd1, R_RESP = 2'd2, R_SRESP = 2'd3} r_state_t;

  // Offset from base wraps above G_SIZE when addr < base, so one compare covers both bounds.
  function automatic logic in_window(input logic [G_ADDR_W-1:0] addr);
    logic [G_ADDR_W:0] off;
    off = {1'b0, addr} - {1'b0, G_BASE};
    return (off < G_SIZE);
  endfunction

  // Write path state
  w_state_t                  w_state_q;
  logic                      w_rdy_q;
  logic                      m_awvalid_q, m_wvalid_q, m_bready_q;
  logic                      s_bvalid_q;
  logic [1:0]                s_bresp_q;
  logic [G_ADDR_W-1:0]       aw_addr_q;
  logic [2:0]                aw_prot_q;
  logic [G_DATA_W-1:0]       w_data_q;
  logic [G_DATA_W/8-1:0]     w_strb_q;
  logic [G_WD_WDT-1:0]       wr_wd_q;
  logic                      wr_hung_q;

  // Read path state
  r_state_t                  r_state_q;
  logic                      r_rdy_q;
  logic                      m_arvalid_q, m_rready_q;
  logic                      s_rvalid_q;
  logic [1:0]                s_rresp_q;
  logic [G_DATA_W-1:0]       s_rdata_q;
  logic [G_ADDR_W-1:0]       ar_addr_q;
  logic [2:0]                ar_prot_q;
  logic [G_WD_WDT-1:0]       rd_wd_q;
  logic                      rd_hung_q;

  logic [5:0][G_CNT_WDT-1:0] cnt_q;
  logic                      irq_q;

  // Per-edge decisions
  logic                      wr_hs_d, wr_win_d, wr_fwd_done_d, wr_cpl_d, wr_to_d;
  logic                      rd_hs_d, rd_win_d, rd_fwd_done_d, rd_cpl_d, rd_to_d;
  logic [G_WD_WDT:0]         wr_wd_d, rd_wd_d;
  logic [5:0]                inc_d;

  // Handshake, completion and watchdog decisions for both paths
  always_comb begin
    wr_hs_d       = w_rdy_q && s_axil_awvalid && s_axil_wvalid;
    wr_win_d      = in_window(s_axil_awaddr);
    wr_wd_d       = {1'b0, wr_wd_q} + {{G_WD_WDT{1'b0}}, 1'b1};
    wr_fwd_done_d = (w_state_q == W_FWD) && (!m_awvalid_q || m_axil_awready)
                    && (!m_wvalid_q || m_axil_wready);
    wr_cpl_d      = (w_state_q == W_RESP) && m_axil_bvalid && m_bready_q;
    // A completing handshake on the expiry edge takes precedence over the timeout.
    wr_to_d       = ((w_state_q == W_FWD) || (w_state_q == W_RESP)) && (i_len != '0)
                    && (wr_wd_d >= {1'b0, i_len}) && !wr_fwd_done_d && !wr_cpl_d;

    rd_hs_d       = r_rdy_q && s_axil_arvalid;
    rd_win_d      = in_window(s_axil_araddr);
    rd_wd_d       = {1'b0, rd_wd_q} + {{G_WD_WDT{1'b0}}, 1'b1};
    rd_fwd_done_d = (r_state_q == R_FWD) && (!m_arvalid_q || m_axil_arready);
    rd_cpl_d      = (r_state_q == R_RESP) && m_axil_rvalid && m_rready_q;
    rd_to_d       = ((r_state_q == R_FWD) || (r_state_q == R_RESP)) && (i_len != '0)
                    && (rd_wd_d >= {1'b0, i_len}) && !rd_fwd_done_d && !rd_cpl_d;

    inc_d    = 6'b000000;
    inc_d[0] = wr_cpl_d && (m_axil_bresp == 2'b10);
    inc_d[1] = wr_hs_d && !wr_win_d;
    inc_d[2] = wr_to_d;
    inc_d[3] = rd_cpl_d && (m_axil_rresp == 2'b10);
    inc_d[4] = rd_hs_d && !rd_win_d;
    inc_d[5] = rd_to_d;
  end

  // Write path FSM with registered handshake and payload outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      w_state_q   <= W_IDLE;
      w_rdy_q     <= 1'b0;
      m_awvalid_q <= 1'b0;
      m_wvalid_q  <= 1'b0;
      m_bready_q  <= 1'b0;
      s_bvalid_q  <= 1'b0;
      s_bresp_q   <= 2'b00;
      aw_addr_q   <= '0;
      aw_prot_q   <= 3'b000;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      wr_wd_q     <= '0;
      wr_hung_q   <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          m_bready_q <= wr_hung_q && !i_clr;
          if (wr_hs_d) begin
            w_rdy_q   <= 1'b0;
            aw_addr_q <= s_axil_awaddr;
            aw_prot_q <= s_axil_awprot;
            w_data_q  <= s_axil_wdata;
            w_strb_q  <= s_axil_wstrb;
            if (!wr_win_d) begin
              s_bvalid_q <= 1'b1;
              s_bresp_q  <= 2'b11;
              w_state_q  <= W_SRESP;
            end else if (wr_hung_q) begin
              s_bvalid_q <= 1'b1;
              s_bresp_q  <= 2'b10;
              w_state_q  <= W_SRESP;
            end else begin
              m_awvalid_q <= 1'b1;
              m_wvalid_q  <= 1'b1;
              m_bready_q  <= 1'b0;
              wr_wd_q     <= '0;
              w_state_q   <= W_FWD;
            end
          end else begin
            w_rdy_q <= s_axil_awvalid && s_axil_wvalid && !w_rdy_q;
          end
        end
        W_FWD: begin
          wr_wd_q <= wr_wd_d[G_WD_WDT-1:0];
          if (m_axil_awready) m_awvalid_q <= 1'b0;
          if (m_axil_wready)  m_wvalid_q  <= 1'b0;
          if (wr_fwd_done_d) begin
            m_bready_q <= 1'b1;
            w_state_q  <= W_RESP;
          end else if (wr_to_d) begin
            m_awvalid_q <= 1'b0;
            m_wvalid_q  <= 1'b0;
            m_bready_q  <= !i_clr;
            wr_hung_q   <= 1'b1;
            s_bvalid_q  <= 1'b1;
            s_bresp_q   <= 2'b10;
            w_state_q   <= W_SRESP;
          end
        end
        W_RESP: begin
          wr_wd_q <= wr_wd_d[G_WD_WDT-1:0];
          if (wr_cpl_d) begin
            m_bready_q <= 1'b0;
            s_bvalid_q <= 1'b1;
            s_bresp_q  <= m_axil_bresp;
            w_state_q  <= W_SRESP;
          end else if (wr_to_d) begin
            m_bready_q <= !i_clr;
            wr_hung_q  <= 1'b1;
            s_bvalid_q <= 1'b1;
            s_bresp_q  <= 2'b10;
            w_state_q  <= W_SRESP;
          end
        end
        W_SRESP: begin
          m_bready_q <= wr_hung_q && !i_clr;
          if (s_axil_bready) begin
            s_bvalid_q <= 1'b0;
            w_state_q  <= W_IDLE;
          end
        end
        default: begin
          w_state_q <= W_IDLE;
        end
      endcase
      if (i_clr) wr_hung_q <= 1'b0;
    end
  end

  // Read path FSM; isolated or rejected reads return zero data
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state_q   <= R_IDLE;
      r_rdy_q     <= 1'b0;
      m_arvalid_q <= 1'b0;
      m_rready_q  <= 1'b0;
      s_rvalid_q  <= 1'b0;
      s_rresp_q   <= 2'b00;
      s_rdata_q   <= '0;
      ar_addr_q   <= '0;
      ar_prot_q   <= 3'b000;
      rd_wd_q     <= '0;
      rd_hung_q   <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          m_rready_q <= rd_hung_q && !i_clr;
          if (rd_hs_d) begin
            r_rdy_q   <= 1'b0;
            ar_addr_q <= s_axil_araddr;
            ar_prot_q <= s_axil_arprot;
            if (!rd_win_d) begin
              s_rvalid_q <= 1'b1;
              s_rresp_q  <= 2'b11;
              s_rdata_q  <= '0;
              r_state_q  <= R_SRESP;
            end else if (rd_hung_q) begin
              s_rvalid_q <= 1'b1;
              s_rresp_q  <= 2'b10;
              s_rdata_q  <= '0;
              r_state_q  <= R_SRESP;
            end else begin
              m_arvalid_q <= 1'b1;
              m_rready_q  <= 1'b0;
              rd_wd_q     <= '0;
              r_state_q   <= R_FWD;
            end
          end else begin
            r_rdy_q <= s_axil_arvalid && !r_rdy_q;
          end
        end
        R_FWD: begin
          rd_wd_q <= rd_wd_d[G_WD_WDT-1:0];
          if (rd_fwd_done_d) begin
            m_arvalid_q <= 1'b0;
            m_rready_q  <= 1'b1;
            r_state_q   <= R_RESP;
          end else if (rd_to_d) begin
            m_arvalid_q <= 1'b0;
            m_rready_q  <= !i_clr;
            rd_hung_q   <= 1'b1;
            s_rvalid_q  <= 1'b1;
            s_rresp_q   <= 2'b10;
            s_rdata_q   <= '0;
            r_state_q   <= R_SRESP;
          end
        end
        R_RESP: begin
          rd_wd_q <= rd_wd_d[G_WD_WDT-1:0];
          if (rd_cpl_d) begin
            m_rready_q <= 1'b0;
            s_rvalid_q <= 1'b1;
            s_rresp_q  <= m_axil_rresp;
            s_rdata_q  <= m_axil_rdata;
            r_state_q  <= R_SRESP;
          end else if (rd_to_d) begin
            m_rready_q <= !i_clr;
            rd_hung_q  <= 1'b1;
            s_rvalid_q <= 1'b1;
            s_rresp_q  <= 2'b10;
            s_rdata_q  <= '0;
            r_state_q  <= R_SRESP;
          end
        end
        R_SRESP: begin
          m_rready_q <= rd_hung_q && !i_clr;
          if (s_axil_rready) begin
            s_rvalid_q <= 1'b0;
            r_state_q  <= R_IDLE;
          end
        end
        default: begin
          r_state_q <= R_IDLE;
        end
      endcase
      if (i_clr) rd_hung_q <= 1'b0;
    end
  end

  // Saturating error counters; clear beats a same-cycle increment
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      irq_q <= |inc_d;
      for (int i = 0; i < 6; i++) begin
        if (i_clr) begin
          cnt_q[i] <= '0;
        end else if (inc_d[i] && (cnt_q[i] != {G_CNT_WDT{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + {{(G_CNT_WDT-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign s_axil_awready = w_rdy_q;
  assign s_axil_wready  = w_rdy_q;
  assign s_axil_bvalid  = s_bvalid_q;
  assign s_axil_bresp   = s_bresp_q;
  assign s_axil_arready = r_rdy_q;
  assign s_axil_rvalid  = s_rvalid_q;
  assign s_axil_rdata   = s_rdata_q;
  assign s_axil_rresp   = s_rresp_q;
  assign m_axil_awvalid = m_awvalid_q;
  assign m_axil_awaddr  = aw_addr_q;
  assign m_axil_awprot  = aw_prot_q;
  assign m_axil_wvalid  = m_wvalid_q;
  assign m_axil_wdata   = w_data_q;
  assign m_axil_wstrb   = w_strb_q;
  assign m_axil_bready  = m_bready_q;
  assign m_axil_arvalid = m_arvalid_q;
  assign m_axil_araddr  = ar_addr_q;
  assign m_axil_arprot  = ar_prot_q;
  assign m_axil_rready  = m_rready_q;
  assign o_wr_hung      = wr_hung_q;
  assign o_rd_hung      = rd_hung_q;
  assign o_err_cnt      = cnt_q;
  assign o_irq          = irq_q;

endmodule

// File: tb/tb_axil_fw_wdg.sv
// Directed bench for axil_fw_wdg: forwarding, window DECERR, watchdog hang/clear,
// counter saturation, completion-vs-timeout race and mid-transaction reset.
module tb_axil_fw_wdg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  len = 8'd0;
  logic        clr = 1'b0;
  logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b1, s_arvalid = 1'b0, s_rready = 1'b1;
  logic [19:0] s_awaddr = 20'h0, s_araddr = 20'h0;
  logic [2:0]  s_awprot = 3'b000, s_arprot = 3'b000;
  logic [31:0] s_wdata = 32'h0;
  logic [3:0]  s_wstrb = 4'h0;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [19:0] m_awaddr, m_araddr;
  logic [2:0]  m_awprot, m_arprot;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_awready = 1'b1, m_wready = 1'b1, m_arready = 1'b1;
  logic        m_bvalid = 1'b0, m_rvalid = 1'b0;
  logic [1:0]  m_bresp = 2'b00, m_rresp = 2'b00;
  logic [31:0] m_rdata = 32'h0;
  logic        wr_hung, rd_hung, irq;
  logic [23:0] err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axil_fw_wdg dut (
    .i_clk(clk), .i_rst(rst), .i_len(len), .i_clr(clr),
    .s_axil_awvalid(s_awvalid), .s_axil_awaddr(s_awaddr), .s_axil_awprot(s_awprot),
    .s_axil_awready(s_awready),
    .s_axil_wvalid(s_wvalid), .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb), .s_axil_wready(s_wready),
    .s_axil_bvalid(s_bvalid), .s_axil_bresp(s_bresp), .s_axil_bready(s_bready),
    .s_axil_arvalid(s_arvalid), .s_axil_araddr(s_araddr), .s_axil_arprot(s_arprot),
    .s_axil_arready(s_arready),
    .s_axil_rvalid(s_rvalid), .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp), .s_axil_rready(s_rready),
    .m_axil_awvalid(m_awvalid), .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot),
    .m_axil_awready(m_awready),
    .m_axil_wvalid(m_wvalid), .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wready(m_wready),
    .m_axil_bvalid(m_bvalid), .m_axil_bresp(m_bresp), .m_axil_bready(m_bready),
    .m_axil_arvalid(m_arvalid), .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot),
    .m_axil_arready(m_arready),
    .m_axil_rvalid(m_rvalid), .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rready(m_rready),
    .o_wr_hung(wr_hung), .o_rd_hung(rd_hung), .o_err_cnt(err_cnt), .o_irq(irq)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents AW+W and returns #1 after the accepting edge.
  task automatic wr_accept(input logic [19:0] a, input logic [31:0] d);
    bit seen = 1'b0;
    s_awvalid = 1'b1; s_awaddr = a; s_awprot = 3'b010;
    s_wvalid  = 1'b1; s_wdata  = d; s_wstrb  = 4'hF;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (s_awready && s_wready) seen = 1'b1;
    end
    check_eq("wr_accept", 64'(seen), 64'd1);
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
  endtask

  task automatic rd_accept(input logic [19:0] a);
    bit seen = 1'b0;
    s_arvalid = 1'b1; s_araddr = a; s_arprot = 3'b101;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (s_arready) seen = 1'b1;
    end
    check_eq("rd_accept", 64'(seen), 64'd1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
  endtask

  task automatic wr_resp_wait(input logic [1:0] exp);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (s_bvalid) begin
        seen = 1'b1;
        check_eq("s_bresp", 64'(s_bresp), 64'(exp));
      end
    end
    check_eq("s_bvalid_seen", 64'(seen), 64'd1);
  endtask

  task automatic rd_resp_wait(input logic [1:0] exp, input logic [31:0] exp_d);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (s_rvalid) begin
        seen = 1'b1;
        check_eq("s_rresp", 64'(s_rresp), 64'(exp));
        check_eq("s_rdata", 64'(s_rdata), 64'(exp_d));
      end
    end
    check_eq("s_rvalid_seen", 64'(seen), 64'd1);
  endtask

  // Forwarded write: downstream sees it one cycle after accept, slave answers with sresp.
  task automatic wr_full(input logic [19:0] a, input logic [31:0] d, input logic [1:0] sresp);
    wr_accept(a, d);
    @(negedge clk);
    check_eq("m_awvalid", 64'(m_awvalid), 64'd1);
    check_eq("m_wvalid", 64'(m_wvalid), 64'd1);
    check_eq("m_awaddr", 64'(m_awaddr), 64'(a));
    check_eq("m_wdata", 64'(m_wdata), 64'(d));
    check_eq("m_awprot", 64'(m_awprot), 64'd2);
    check_eq("m_wstrb", 64'(m_wstrb), 64'hF);
    @(posedge clk); @(negedge clk);
    check_eq("m_awvalid_drop", 64'(m_awvalid), 64'd0);
    check_eq("m_bready", 64'(m_bready), 64'd1);
    m_bvalid = 1'b1; m_bresp = sresp;
    @(posedge clk); #1;
    m_bvalid = 1'b0;
    wr_resp_wait(sresp);
  endtask

  task automatic rd_full(input logic [19:0] a, input logic [31:0] d, input logic [1:0] sresp);
    rd_accept(a);
    @(negedge clk);
    check_eq("m_arvalid", 64'(m_arvalid), 64'd1);
    check_eq("m_araddr", 64'(m_araddr), 64'(a));
    check_eq("m_arprot", 64'(m_arprot), 64'd5);
    @(posedge clk); @(negedge clk);
    check_eq("m_rready", 64'(m_rready), 64'd1);
    m_rvalid = 1'b1; m_rdata = d; m_rresp = sresp;
    @(posedge clk); #1;
    m_rvalid = 1'b0;
    rd_resp_wait(sresp, d);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check_eq("clr_cnt", 64'(err_cnt), 64'd0);
    check_eq("clr_wr_hung", 64'(wr_hung), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_awready", 64'(s_awready), 64'd0);
    check_eq("rst_bvalid", 64'(s_bvalid), 64'd0);
    check_eq("rst_m_awvalid", 64'(m_awvalid), 64'd0);
    check_eq("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    check_eq("rst_m_bready", 64'(m_bready), 64'd0);
    check_eq("rst_rvalid", 64'(s_rvalid), 64'd0);
    check_eq("rst_cnt", 64'(err_cnt), 64'd0);
    check_eq("rst_hung", 64'({wr_hung, rd_hung}), 64'd0);
    check_eq("rst_irq", 64'(irq), 64'd0);
    rst = 1'b0;

    // Plain forwarded write
    wr_full(20'h00010, 32'hA5A5A5A5, 2'b00);
    check_eq("t1_cnt", 64'(err_cnt), 64'd0);
    check_eq("t1_irq", 64'(irq), 64'd0);

    // Out-of-window read answered locally
    rd_accept(20'h20000);
    @(negedge clk);
    check_eq("t2_rvalid", 64'(s_rvalid), 64'd1);
    check_eq("t2_rresp", 64'(s_rresp), 64'd3);
    check_eq("t2_rdata", 64'(s_rdata), 64'd0);
    check_eq("t2_m_arvalid", 64'(m_arvalid), 64'd0);
    check_eq("t2_cnt", 64'(err_cnt), 64'h010000);
    check_eq("t2_irq", 64'(irq), 64'd1);
    @(negedge clk);
    check_eq("t2_irq_pulse", 64'(irq), 64'd0);
    check_eq("t2_m_arvalid2", 64'(m_arvalid), 64'd0);

    // Window edges: first illegal write address, last legal read address
    wr_accept(20'h10000, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("edge_bvalid", 64'(s_bvalid), 64'd1);
    check_eq("edge_bresp", 64'(s_bresp), 64'd3);
    check_eq("edge_m_awvalid", 64'(m_awvalid), 64'd0);
    check_eq("edge_cnt", 64'(err_cnt), 64'h010010);
    rd_full(20'h0FFFC, 32'h12345678, 2'b00);
    pulse_clr();

    // Watchdog expiry on a write with no downstream response
    len = 8'd8;
    wr_accept(20'h00100, 32'h11111111);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check_eq("t3_not_yet", 64'(s_bvalid), 64'd0);
    check_eq("t3_not_hung", 64'(wr_hung), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("t3_bvalid", 64'(s_bvalid), 64'd1);
    check_eq("t3_bresp", 64'(s_bresp), 64'd2);
    check_eq("t3_hung", 64'(wr_hung), 64'd1);
    check_eq("t3_cnt", 64'(err_cnt), 64'h000100);
    check_eq("t3_irq", 64'(irq), 64'd1);
    check_eq("t3_absorb", 64'(m_bready), 64'd1);
    wr_accept(20'h00104, 32'h99999999);
    @(negedge clk);
    check_eq("t3_iso_awvalid", 64'(m_awvalid), 64'd0);
    check_eq("t3_iso_bvalid", 64'(s_bvalid), 64'd1);
    check_eq("t3_iso_bresp", 64'(s_bresp), 64'd2);
    check_eq("t3_iso_cnt", 64'(err_cnt), 64'h000100);
    m_bvalid = 1'b1; m_bresp = 2'b00;
    @(posedge clk); #1;
    m_bvalid = 1'b0;
    @(negedge clk);
    check_eq("t3_late_drop", 64'(s_bvalid), 64'd0);
    check_eq("t3_still_hung", 64'(wr_hung), 64'd1);
    pulse_clr();
    check_eq("t3_clr_bready", 64'(m_bready), 64'd0);
    wr_full(20'h00108, 32'h22222222, 2'b00);

    // Repeated slave SLVERR on reads: counter saturates at 15, irq every time
    for (int i = 0; i < 17; i++) begin
      rd_full(20'h00400 + 20'(i * 4), 32'hC0DE0000 + 32'(i), 2'b10);
      check_eq("t4_irq", 64'(irq), 64'd1);
      check_eq("t4_cnt", 64'(err_cnt), 64'(((i + 1 > 15) ? 15 : i + 1) << 12));
    end

    // Reset while waiting for a write response
    wr_accept(20'h00040, 32'h33333333);
    @(posedge clk); @(negedge clk);
    check_eq("t6_in_resp", 64'(m_bready), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("t6_valids", 64'({m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}), 64'd0);
    check_eq("t6_bready", 64'(m_bready), 64'd0);
    check_eq("t6_cnt", 64'(err_cnt), 64'd0);
    check_eq("t6_irq", 64'(irq), 64'd0);
    wr_full(20'h00044, 32'h44444444, 2'b00);

    // Response lands on the expiry edge: completion wins
    wr_accept(20'h00080, 32'h55555555);
    repeat (7) @(posedge clk);
    #1;
    m_bvalid = 1'b1; m_bresp = 2'b00;
    @(posedge clk); #1;
    m_bvalid = 1'b0;
    @(negedge clk);
    check_eq("t5_bvalid", 64'(s_bvalid), 64'd1);
    check_eq("t5_bresp", 64'(s_bresp), 64'd0);
    check_eq("t5_hung", 64'(wr_hung), 64'd0);
    check_eq("t5_cnt", 64'(err_cnt), 64'd0);

    // Slave SLVERR on a write bumps wr_slv
    wr_full(20'h000C0, 32'h66666666, 2'b10);
    check_eq("wslv_cnt", 64'(err_cnt), 64'h000001);
    check_eq("wslv_irq", 64'(irq), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
